multi_gate_occupancy: RTL and testbench

- Parametrised successor to the single-gate car detector: NUM_GATES independent gates, each with outer/inner beam sensors.
- Per gate: synchronises and debounces both sensors, then runs a direction FSM that emits one-cycle enter/exit pulses.
- Aggregates all gates into a saturating occupancy counter with full/empty flags and a sticky error flag.
- Sits between raw lot sensors and the display/HEX logic.

---
 rtl/multi_gate_occupancy.sv | 157 +++++++++++++++
 tb/tb_multi_gate_occupancy.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_gate_occupancy.sv
// Multi-gate lot occupancy tracker: per-gate sensor sync/debounce, direction FSM,
// and a saturating occupancy counter with full/empty and sticky error flags.
module multi_gate_occupancy #(
  parameter int NUM_GATES = 2,
  parameter int DEBOUNCE  = 4,
  parameter int CAPACITY  = 15,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] outer,
  input  logic [NUM_GATES-1:0] inner,
  output logic [NUM_GATES-1:0] enter,
  output logic [NUM_GATES-1:0] exit,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  // state | meaning
  // IDLE  | no vehicle in the gate
  // E1    | entering, outer beam blocked
  // E2    | entering, both beams blocked
  // E3    | entering, inner beam only
  // X1    | exiting, inner beam blocked
  // X2    | exiting, both beams blocked
  // X3    | exiting, outer beam only
  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} state_t;

  localparam int NS  = 2 * NUM_GATES;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int SW  = CNT_W + 2;

  // sensor index s < NUM_GATES is outer[s], otherwise inner[s-NUM_GATES]
  logic [NS-1:0]        raw;
  logic [NS-1:0]        sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [DBW-1:0]       db_q [NS];
  logic [DBW-1:0]       db_d [NS];
  state_t               state_q [NUM_GATES];
  state_t               state_d [NUM_GATES];
  logic [NUM_GATES-1:0] enter_q, enter_d, exit_q, exit_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;
  logic signed [SW-1:0] ne, nx, next_s;
  logic [1:0]           oi;

  assign raw = {inner, outer};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int s = 0; s < NS; s++) begin
      db_d[s] = '0;
      if (sync2_q[s] != filt_q[s]) begin
        if (db_q[s] == DBW'(DEBOUNCE)) filt_d[s] = sync2_q[s];
        else                           db_d[s]   = db_q[s] + 1'b1;
      end
    end
  end

  always_comb begin
    oi = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      state_d[g] = state_q[g];
      enter_d[g] = 1'b0;
      exit_d[g]  = 1'b0;
      oi = {filt_q[g], filt_q[NUM_GATES+g]};
      case (state_q[g])
        IDLE: if (oi == 2'b10) state_d[g] = E1;
              else if (oi == 2'b01) state_d[g] = X1;
        E1:   if (oi == 2'b11) state_d[g] = E2;
              else if (oi != 2'b10) state_d[g] = IDLE;
        E2:   case (oi)
                2'b01:   state_d[g] = E3;
                2'b10:   state_d[g] = E1;
                2'b00:   state_d[g] = IDLE;
                default: state_d[g] = E2;
              endcase
        E3:   case (oi)
                2'b00:   begin state_d[g] = IDLE; enter_d[g] = 1'b1; end
                2'b11:   state_d[g] = E2;
                2'b10:   state_d[g] = IDLE;
                default: state_d[g] = E3;
              endcase
        X1:   if (oi == 2'b11) state_d[g] = X2;
              else if (oi != 2'b01) state_d[g] = IDLE;
        X2:   case (oi)
                2'b10:   state_d[g] = X3;
                2'b01:   state_d[g] = X1;
                2'b00:   state_d[g] = IDLE;
                default: state_d[g] = X2;
              endcase
        X3:   case (oi)
                2'b00:   begin state_d[g] = IDLE; exit_d[g] = 1'b1; end
                2'b11:   state_d[g] = X2;
                2'b01:   state_d[g] = IDLE;
                default: state_d[g] = X3;
              endcase
        default: state_d[g] = IDLE;
      endcase
    end
  end

  // counter acts on the registered pulses, so it lags them by one cycle
  always_comb begin
    ne = '0;
    nx = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      ne = ne + SW'(enter_q[g]);
      nx = nx + SW'(exit_q[g]);
    end
    next_s  = $signed({2'b00, count_q}) + ne - nx;
    count_d = next_s[CNT_W-1:0];
    err_d   = err_q;
    if (next_s > $signed(SW'(CAPACITY))) begin
      count_d = CNT_W'(CAPACITY);
      err_d   = 1'b1;
    end else if (next_s < 0) begin
      count_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int s = 0; s < NS; s++) db_q[s] <= '0;
      for (int g = 0; g < NUM_GATES; g++) state_q[g] <= IDLE;
      enter_q <= '0;
      exit_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      for (int s = 0; s < NS; s++) db_q[s] <= db_d[s];
      for (int g = 0; g < NUM_GATES; g++) state_q[g] <= state_d[g];
      enter_q <= enter_d;
      exit_q  <= exit_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign enter = enter_q;
  assign exit  = exit_q;
  assign count = count_q;
  assign full  = (count_q == CNT_W'(CAPACITY));
  assign empty = (count_q == '0);
  assign err   = err_q;

endmodule

// File: tb/tb_multi_gate_occupancy.sv
// Directed bench for multi_gate_occupancy: entries, exits, saturation, filtering and reset.
module tb_multi_gate_occupancy;

  localparam int NG  = 2;
  localparam int DB  = 2;
  localparam int CAP = 3;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NG-1:0] outer, inner, enter, exit;
  logic [CW-1:0] count;
  logic          full, empty, err;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt [NG];
  int ex_cnt [NG];

  multi_gate_occupancy #(.NUM_GATES(NG), .DEBOUNCE(DB), .CAPACITY(CAP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .outer(outer), .inner(inner),
    .enter(enter), .exit(exit), .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NG; g++) begin
        en_cnt[g] += int'(enter[g]);
        ex_cnt[g] += int'(exit[g]);
      end
    end
  endtask

  task automatic clr_cnt();
    for (int g = 0; g < NG; g++) begin
      en_cnt[g] = 0;
      ex_cnt[g] = 0;
    end
  endtask

  task automatic drive(input int g, input logic o, input logic i);
    outer[g] = o;
    inner[g] = i;
  endtask

  task automatic seq(input int g, input bit is_entry);
    if (is_entry) begin
      drive(g, 1, 0); hold(6);
      drive(g, 1, 1); hold(6);
      drive(g, 0, 1); hold(6);
    end else begin
      drive(g, 0, 1); hold(6);
      drive(g, 1, 1); hold(6);
      drive(g, 1, 0); hold(6);
    end
    drive(g, 0, 0); hold(8);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    hold(1);
    reset = 1'b1;
  endtask

  initial begin
    outer = '0;
    inner = '0;
    reset = 1'b0;
    clr_cnt();
    hold(2);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_enter", enter, 0);
    chk("rst_exit", exit, 0);
    reset = 1'b1;
    hold(2);

    // gate0 entry with cycle-exact pulse latency
    drive(0, 1, 0); hold(6);
    drive(0, 1, 1); hold(6);
    drive(0, 0, 1); hold(6);
    drive(0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      hold(1);
      chk($sformatf("s1_enter_e%0d", k), enter[0], 32'(k == DB + 4));
      if (k == DB + 4) begin
        chk("s1_count_lag", count, 0);
        chk("s1_empty_lag", empty, 1);
      end
    end
    chk("s1_count", count, 1);
    chk("s1_empty", empty, 0);

    // gate1 exit to zero, then underflow attempt
    clr_cnt();
    seq(1, 0);
    chk("s2_exit_pulses", ex_cnt[1], 1);
    chk("s2_enter_pulses", en_cnt[1], 0);
    chk("s2_count", count, 0);
    chk("s2_empty", empty, 1);
    chk("s2_err", err, 0);
    clr_cnt();
    seq(1, 0);
    chk("s2u_exit_pulses", ex_cnt[1], 1);
    chk("s2u_count", count, 0);
    chk("s2u_err", err, 1);
    hold(10);
    chk("s2u_err_sticky", err, 1);

    // simultaneous entry on gate0 and exit on gate1 at count=2
    do_reset();
    chk("s3_rst_err", err, 0);
    seq(0, 1);
    seq(0, 1);
    chk("s3_count_pre", count, 2);
    clr_cnt();
    drive(0, 1, 0); drive(1, 0, 1); hold(6);
    drive(0, 1, 1); drive(1, 1, 1); hold(6);
    drive(0, 0, 1); drive(1, 1, 0); hold(6);
    drive(0, 0, 0); drive(1, 0, 0); hold(DB + 4);
    chk("s3_enter0", enter[0], 1);
    chk("s3_exit1", exit[1], 1);
    hold(1);
    chk("s3_count", count, 2);
    chk("s3_err", err, 0);
    hold(2);
    chk("s3_enter_total", en_cnt[0], 1);
    chk("s3_exit_total", ex_cnt[1], 1);

    // back-out, then short inner glitches while gate0 sits in E1
    clr_cnt();
    drive(0, 1, 0); hold(6);
    drive(0, 1, 1); hold(6);
    drive(0, 1, 0); hold(6);
    drive(0, 0, 0); hold(8);
    chk("s4_backout_enter", en_cnt[0], 0);
    chk("s4_backout_exit", ex_cnt[0], 0);
    chk("s4_backout_count", count, 2);
    drive(0, 1, 0); hold(6);
    repeat (2) begin
      inner[0] = 1'b1;
      hold(1);
      inner[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
        hold(1);
        chk("s4_glitch_filt", dut.filt_q[NG], 0);
      end
    end
    chk("s4_outer_filt", dut.filt_q[0], 1);
    drive(0, 0, 0); hold(8);
    chk("s4_glitch_enter", en_cnt[0], 0);
    chk("s4_glitch_count", count, 2);

    // four entries against CAPACITY=3
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      clr_cnt();
      seq(0, 1);
      chk($sformatf("s5_pulse_%0d", n), en_cnt[0], 1);
      chk($sformatf("s5_count_%0d", n), count, (n > CAP) ? CAP : n);
      chk($sformatf("s5_full_%0d", n), full, 32'(n >= CAP));
      chk($sformatf("s5_err_%0d", n), err, 32'(n > CAP));
    end

    // reset while gate0 is in E3 with count=2
    do_reset();
    seq(0, 1);
    seq(0, 1);
    chk("s6_count_pre", count, 2);
    drive(0, 1, 0); hold(6);
    drive(0, 1, 1); hold(6);
    drive(0, 0, 1); hold(6);
    clr_cnt();
    do_reset();
    chk("s6_count", count, 0);
    chk("s6_err", err, 0);
    chk("s6_empty", empty, 1);
    chk("s6_enter", enter, 0);
    hold(6);
    drive(0, 0, 0); hold(8);
    chk("s6_no_enter", en_cnt[0], 0);
    chk("s6_no_exit", ex_cnt[0], 0);
    chk("s6_count_post", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
